// File: rtl/nes_pkg.sv
// Shared constants, event encoding and scanner state for nes_button_events.
// Latency: none, declarations only.
// Backpressure: not applicable.
package nes_pkg;

  // Button vector and index widths
  localparam int NES_BTN_W = 8;
  localparam int NES_IDX_W = 3;

  // Event word layout: {press, idx[2:0]}
  localparam int EVT_W         = 4;
  localparam int EVT_PRESS_BIT = 3;
  localparam int EVT_IDX_LSB   = 0;

  // Button bit indices in nesController shift order
  localparam logic [NES_IDX_W-1:0] BTN_A      = 3'd0;
  localparam logic [NES_IDX_W-1:0] BTN_B      = 3'd1;
  localparam logic [NES_IDX_W-1:0] BTN_SELECT = 3'd2;
  localparam logic [NES_IDX_W-1:0] BTN_START  = 3'd3;
  localparam logic [NES_IDX_W-1:0] BTN_UP     = 3'd4;
  localparam logic [NES_IDX_W-1:0] BTN_DOWN   = 3'd5;
  localparam logic [NES_IDX_W-1:0] BTN_LEFT   = 3'd6;
  localparam logic [NES_IDX_W-1:0] BTN_RIGHT  = 3'd7;

  // Scanner walks the change mask one bit per cycle after each commit
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  // Pack a press flag and button index into an event word
  function automatic logic [EVT_W-1:0] make_evt(input logic press,
                                                input logic [NES_IDX_W-1:0] idx);
    logic [EVT_W-1:0] e;
    e = '0;
    e[EVT_PRESS_BIT] = press;
    e[EVT_IDX_LSB +: NES_IDX_W] = idx;
    return e;
  endfunction

endpackage

// File: rtl/nes_evt_fifo.sv
// First-word-fall-through event FIFO with exact occupancy count and drop flag.
// Latency: pushed word is visible at the head the cycle after the push edge.
// Backpressure: a push into a full FIFO without a same-cycle pop is dropped and flagged.
import nes_pkg::*;

module nes_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = EVT_W
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  logic [W-1:0]           push_dat_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_dat_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign count_o = count_q;

  // A pop frees the slot a full-cycle push needs; an empty FIFO cannot pop
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & full_o & ~do_pop;

  // Head is forced to zero when empty so stale storage never leaks out
  assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage write; contents need no reset because the head is gated by empty
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/nes_button_events.sv
// Debounces the NES button vector and queues one event per committed button change.
// Latency: btn_state follows a held input STABLE_CYCLES+1 edges after it is sampled; events follow at commit+1+idx.
// Backpressure: events arriving at a full FIFO are dropped and latch the sticky overflow flag.
// Build option NES_EVT_RELEASE_EN: when defined, releases are queued as well as presses.
import nes_pkg::*;

module nes_button_events #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NES_BTN_W-1:0]        btn_n_in,
  output logic [NES_BTN_W-1:0]        btn_state,
  output logic                        evt_valid,
  output logic [EVT_W-1:0]            evt_data,
  input  logic                        evt_pop,
  output logic [$clog2(FIFO_DEPTH):0] evt_count,
  output logic                        overflow,
  input  logic                        clr_overflow
);

  localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [NES_IDX_W-1:0] IDX_LAST = NES_IDX_W'(NES_BTN_W - 1);
  localparam logic [NES_IDX_W-1:0] IDX_ONE  = NES_IDX_W'(1);

  // Input and debounce registers
  logic [NES_BTN_W-1:0] s_in_q;
  logic [NES_BTN_W-1:0] cand_q;
  logic [CNT_W-1:0]     cnt_q;

  // Scanner registers
  scan_state_t          state_q;
  logic [NES_IDX_W-1:0] idx_q;
  logic [NES_BTN_W-1:0] chg_q;
  logic [NES_BTN_W-1:0] lvl_q;
  logic [NES_BTN_W-1:0] btn_state_q;

  logic                 overflow_q;
  logic                 commit;
  logic                 scanning;
  logic                 evt_push;
  logic [EVT_W-1:0]     evt_word;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 fifo_drop;

  // Invert to active-high and track how long the vector has been stable
  always_ff @(posedge clk) begin
    if (reset) begin
      s_in_q <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      s_in_q <= ~btn_n_in;
      if (s_in_q != cand_q) begin
        cand_q <= s_in_q;
        cnt_q  <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  // A stable new vector commits only while idle; during a scan the counter
  // sits saturated so the commit is taken on the first idle cycle
  assign commit   = (cnt_q == CNT_MAX) && (cand_q != btn_state_q) && (state_q == ST_IDLE);
  assign scanning = (state_q == ST_SCAN);

  // Commit the level, latch the change mask, then walk it one index per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      chg_q       <= '0;
      lvl_q       <= '0;
      btn_state_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (commit) begin
            btn_state_q <= cand_q;
            chg_q       <= cand_q ^ btn_state_q;
            lvl_q       <= cand_q;
            idx_q       <= '0;
            state_q     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          idx_q <= idx_q + IDX_ONE;
          if (idx_q == IDX_LAST) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef NES_EVT_RELEASE_EN
  // Every changed bit produces an event carrying its new level
  assign evt_push = scanning & chg_q[idx_q];
  assign evt_word = make_evt(lvl_q[idx_q], idx_q);
`else
  // Only presses are reported; the scan still spends one cycle per index
  assign evt_push = scanning & chg_q[idx_q] & lvl_q[idx_q];
  assign evt_word = make_evt(1'b1, idx_q);
`endif

  nes_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk_i      (clk),
    .reset_i    (reset),
    .push_i     (evt_push),
    .push_dat_i (evt_word),
    .pop_i      (evt_pop),
    .head_dat_o (evt_data),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .count_o    (evt_count),
    .drop_o     (fifo_drop)
  );

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (fifo_drop) begin
      overflow_q <= 1'b1;
    end else if (clr_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  // A dropped event must only ever come from a full FIFO
  a_drop_only_when_full : assert property (@(posedge clk) disable iff (reset) fifo_drop |-> fifo_full);

  assign btn_state = btn_state_q;
  assign evt_valid = ~fifo_empty;
  assign overflow  = overflow_q;

endmodule
